pr_request_queue_mc: RTL
========================

# pr_request_queue_mc

Multi-channel partial-reconfiguration request queue, successor to the single-queue PR block behind the core's AXI-lite slave. The RCA/issue side pushes reconfiguration requests into one of NUM_CHANNELS independent FIFOs. An external PR controller drains them over AXI-lite with round-robin fairness, then acknowledges completion per channel. Per-channel busy flags let the core stall RCA issue to a region under reconfiguration.

## Interface
- NUM_CHANNELS, 4: independent request channels (1..8)
- DEPTH, 8: entries per channel FIFO (power of two, ≥2)
- DATA_WIDTH, 32: request payload width (≤32)

- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  push request
- req_channel  in  $clog2(NUM_CHANNELS)  target channel
- req_data  in  DATA_WIDTH  request payload
- req_ready  out  1  selected channel not full
- channel_busy  out  NUM_CHANNELS  request popped, not yet acknowledged
- pr_request_pending  out  1  any channel non-empty
- s_axi_awaddr  in  4;  s_axi_awvalid  in  1;  s_axi_awready  out  1
- s_axi_wdata  in  32;  s_axi_wvalid  in  1;  s_axi_wready  out  1
- s_axi_bvalid  out  1;  s_axi_bready  in  1
- s_axi_araddr  in  4;  s_axi_arvalid  in  1;  s_axi_arready  out  1
- s_axi_rdata  out  32;  s_axi_rvalid  out  1;  s_axi_rready  in  1

## Operation
- Push: req_valid && req_ready writes req_data to tail of req_channel; count+1.
- req_ready = count[req_channel] != DEPTH, from registered count. No same-cycle pop bypass.
- Register map, byte offsets:
  - 0x0 read STATUS: [7:0] non-empty mask, [15:8] busy mask; unused bits 0.
  - 0x4 read POP: round-robin selects a non-empty channel, returns its head payload (zero-extended), dequeues it, sets that busy bit, records LAST_CH. If all channels are empty: returns 0xFFFF_FFFF, no side effect.
  - 0x8 read LAST_CH: [31] valid, [2:0] channel of the most recent successful POP.
  - 0x0 write ACK: clears busy bits set in wdata[NUM_CHANNELS-1:0].
  - Other reads return 0. Other writes are ignored. All responses OKAY.
- Round robin: pointer rr starts at 0. Search order is rr, rr+1, … mod NUM_CHANNELS over the registered non-empty mask. After popping channel c, rr = c+1 mod NUM_CHANNELS. rr is unchanged when nothing is popped.
- pr_request_pending = OR of non-empty mask, from registered counts.

## Timing
- Push visible in STATUS, non-empty mask and pr_request_pending one cycle after the handshake.
- Read: s_axi_arready = !s_axi_rvalid. Pop and side effects happen in the AR handshake cycle T. rdata and rvalid are registered and appear at T+1, held until rready.
- Write: awready = wready = awvalid && wvalid && !bvalid. Both are accepted in the same cycle and the effect lands on the next edge. bvalid is asserted the next cycle and held until bready.
- Simultaneous push and pop, same channel:
  - Both occur; count unchanged.
  - On an empty channel, the pop does not see the same-cycle push.
  - On a full channel, the push is refused (req_ready low).
- Simultaneous ACK and POP on the same channel: busy ends set (pop wins).
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits.
- Reset (async assert, sync deassert assumed upstream) clears the following mid-transaction; in-flight AXI responses are dropped:
  - counts, pointers, busy, rr, LAST_CH, bvalid, rvalid, rdata all go to 0.
- Output values in reset:
  - req_ready=1, channel_busy=0, pr_request_pending=0
  - s_axi_arready=1, s_axi_awready=s_axi_wready=0, s_axi_bvalid=0, s_axi_rvalid=0, s_axi_rdata=0

## Structure
- Shared package entries in taiga_types:
  - localparams PRQ_STATUS_OFF=0x0, PRQ_POP_OFF=0x4, PRQ_LASTCH_OFF=0x8
  - PRQ_EMPTY_RDATA=32'hFFFF_FFFF
  - typedef prq_status_t: non-empty mask, busy mask
  - taiga_config: NUM_PR_CHANNELS, PR_QUEUE_DEPTH
- One sub-module, pr_channel_fifo: per-channel LUTRAM FIFO with push, pop, count, full and empty; instantiated NUM_CHANNELS times. The top level holds arbitration, busy flags and the AXI-lite slave.

## Test plan
- Push 0x11 to ch2, then POP read → rdata=0x11, busy=0b0100, LAST_CH=0x8000_0002; STATUS then reads 0x0000_0400.
- Push one entry each to ch0, ch1, ch3, then three POPs → channel order 0, 1, 3; a fourth POP returns 0xFFFF_FFFF and busy is unchanged.
- Fill ch1 with 8 entries → req_ready=0 for ch1 while ch0 is still accepted. Push and POP ch1 in the same cycle when full → push refused, count becomes 7.
- ACK write of 0x5 in the same cycle as an AR pop of ch2 → busy bit2 stays 1, bit0 cleared; bvalid held 3 cycles with bready low.
- Assert rst mid-read with rvalid pending → rvalid=0, arready=1, all counts and busy cleared, pr_request_pending=0.

Source files
------------

// File: rtl/pr_request_queue_mc_pkg.sv
// Shared definitions for the multi-channel PR request queue: AXI-lite register
// offsets, the empty-POP sentinel, the STATUS word layout and default sizing.
package pr_request_queue_mc_pkg;

  // Default sizing
  localparam int unsigned NUM_PR_CHANNELS = 4;
  localparam int unsigned PR_QUEUE_DEPTH  = 8;

  // Register byte offsets
  localparam logic [3:0] PRQ_STATUS_OFF = 4'h0;
  localparam logic [3:0] PRQ_POP_OFF    = 4'h4;
  localparam logic [3:0] PRQ_LASTCH_OFF = 4'h8;

  // Returned by a POP when every channel is empty
  localparam logic [31:0] PRQ_EMPTY_RDATA = 32'hFFFF_FFFF;

  // STATUS[15:8] = busy mask, STATUS[7:0] = non-empty mask
  typedef struct packed {
    logic [7:0] busy;
    logic [7:0] non_empty;
  } prq_status_t;

  function automatic logic [31:0] prq_lastch_word(input logic valid, input logic [2:0] ch);
    return {valid, 28'b0, ch};
  endfunction

endpackage

// File: rtl/pr_request_queue_mc_fifo.sv
// pr_channel_fifo: one request channel's FIFO. Storage has no reset so it maps
// onto distributed RAM; only pointers and occupancy are reset.
//   clk_i/rst_ni  clock, async active-low reset
//   push_i/data_i write data_i to the tail (ignored when full)
//   pop_i         drop the head entry (ignored when empty)
//   head_o        current head payload (valid when !empty_o)
//   full_o/empty_o occupancy flags from the registered count
module pr_channel_fifo #(
  parameter int unsigned  Depth     = 8,
  parameter int unsigned  DataWidth = 32,
  localparam int unsigned PtrW      = $clog2(Depth),
  localparam int unsigned CntW      = PtrW + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 pop_i,
  output logic [DataWidth-1:0] head_o,
  output logic                 full_o,
  output logic                 empty_o
);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q;
  logic                 push, pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign push    = push_i && !full_o;
  assign pop     = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/pr_request_queue_mc.sv
// Multi-channel partial-reconfiguration request queue.
// The issue side pushes requests into per-channel FIFOs; a PR controller drains
// them round-robin through an AXI-lite slave (STATUS/POP/LAST_CH reads, ACK write)
// and per-channel busy flags mark regions popped but not yet acknowledged.
//   req_*            push interface (req_ready_o from registered occupancy)
//   channel_busy_o   popped-not-acked mask
//   pr_request_pending_o  any channel non-empty
//   s_axi_*          AXI-lite slave, 4-bit byte address, OKAY-only responses
module pr_request_queue_mc
  import pr_request_queue_mc_pkg::*;
#(
  parameter int unsigned  NumChannels = NUM_PR_CHANNELS,
  parameter int unsigned  Depth       = PR_QUEUE_DEPTH,
  parameter int unsigned  DataWidth   = 32,
  localparam int unsigned ChW         = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  input  logic [ChW-1:0]         req_channel_i,
  input  logic [DataWidth-1:0]   req_data_i,
  output logic                   req_ready_o,
  output logic [NumChannels-1:0] channel_busy_o,
  output logic                   pr_request_pending_o,
  input  logic [3:0]             s_axi_awaddr_i,
  input  logic                   s_axi_awvalid_i,
  output logic                   s_axi_awready_o,
  input  logic [31:0]            s_axi_wdata_i,
  input  logic                   s_axi_wvalid_i,
  output logic                   s_axi_wready_o,
  output logic                   s_axi_bvalid_o,
  input  logic                   s_axi_bready_i,
  input  logic [3:0]             s_axi_araddr_i,
  input  logic                   s_axi_arvalid_i,
  output logic                   s_axi_arready_o,
  output logic [31:0]            s_axi_rdata_o,
  output logic                   s_axi_rvalid_o,
  input  logic                   s_axi_rready_i
);

  logic [NumChannels-1:0] full, empty, non_empty, push_en, pop_en, ack_mask;
  logic [DataWidth-1:0]   head [NumChannels];
  logic [NumChannels-1:0] busy_q, busy_d;
  logic [ChW-1:0]         rr_q, rr_d, sel_ch;
  logic                   sel_found, ar_hs, aw_hs, pop_req;
  logic                   last_valid_q, last_valid_d;
  logic [2:0]             last_ch_q, last_ch_d;
  logic                   rvalid_q, rvalid_d, bvalid_q, bvalid_d;
  logic [31:0]            rdata_q, rdata_d, rd_word, pop_word;
  prq_status_t            status;
  logic                   unused_wdata;

  assign unused_wdata = ^s_axi_wdata_i[31:NumChannels];

  for (genvar c = 0; c < NumChannels; c++) begin : g_chan
    assign push_en[c] = req_valid_i && req_ready_o && (req_channel_i == ChW'(c));
    assign pop_en[c]  = pop_req && sel_found && (sel_ch == ChW'(c));
    pr_channel_fifo #(
      .Depth    (Depth),
      .DataWidth(DataWidth)
    ) u_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push_i (push_en[c]),
      .data_i (req_data_i),
      .pop_i  (pop_en[c]),
      .head_o (head[c]),
      .full_o (full[c]),
      .empty_o(empty[c])
    );
  end

  assign non_empty            = ~empty;
  assign pr_request_pending_o = |non_empty;
  assign channel_busy_o       = busy_q;

  assign s_axi_arready_o = !rvalid_q;
  assign ar_hs           = s_axi_arvalid_i && s_axi_arready_o;
  assign pop_req         = ar_hs && (s_axi_araddr_i == PRQ_POP_OFF);
  assign s_axi_awready_o = s_axi_awvalid_i && s_axi_wvalid_i && !bvalid_q;
  assign s_axi_wready_o  = s_axi_awready_o;
  assign aw_hs           = s_axi_awready_o;
  assign s_axi_bvalid_o  = bvalid_q;
  assign s_axi_rvalid_o  = rvalid_q;
  assign s_axi_rdata_o   = rdata_q;

  // Push readiness of the addressed channel; out-of-range channels never accept.
  always_comb begin
    req_ready_o = 1'b0;
    for (int unsigned c = 0; c < NumChannels; c++) begin
      if (req_channel_i == ChW'(c)) req_ready_o = !full[c];
    end
  end

  // Round-robin: first non-empty channel at or above rr, else first below rr.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    for (int unsigned c = 0; c < NumChannels; c++) begin
      if (!sel_found && non_empty[c] && (c >= 32'(rr_q))) begin
        sel_found = 1'b1;
        sel_ch    = ChW'(c);
      end
    end
    for (int unsigned c = 0; c < NumChannels; c++) begin
      if (!sel_found && non_empty[c] && (c < 32'(rr_q))) begin
        sel_found = 1'b1;
        sel_ch    = ChW'(c);
      end
    end
  end

  always_comb begin
    pop_word = '0;
    for (int unsigned c = 0; c < NumChannels; c++) begin
      if (sel_ch == ChW'(c)) pop_word = 32'(head[c]);
    end
  end

  always_comb begin
    status                                = '0;
    status.non_empty[NumChannels-1:0]     = non_empty;
    status.busy[NumChannels-1:0]          = busy_q;
    case (s_axi_araddr_i)
      PRQ_STATUS_OFF: rd_word = {16'b0, status};
      PRQ_POP_OFF:    rd_word = sel_found ? pop_word : PRQ_EMPTY_RDATA;
      PRQ_LASTCH_OFF: rd_word = prq_lastch_word(last_valid_q, last_ch_q);
      default:        rd_word = '0;
    endcase
  end

  always_comb begin
    ack_mask     = (aw_hs && (s_axi_awaddr_i == PRQ_STATUS_OFF)) ?
                   s_axi_wdata_i[NumChannels-1:0] : '0;
    // A pop in the same cycle as an ACK leaves its busy bit set.
    busy_d       = (busy_q & ~ack_mask) | pop_en;
    rr_d         = rr_q;
    last_valid_d = last_valid_q;
    last_ch_d    = last_ch_q;
    if (pop_req && sel_found) begin
      rr_d         = (32'(sel_ch) == NumChannels - 1) ? '0 : sel_ch + 1'b1;
      last_valid_d = 1'b1;
      last_ch_d    = 3'(sel_ch);
    end
    bvalid_d = bvalid_q ? !s_axi_bready_i : aw_hs;
    rvalid_d = rvalid_q ? !s_axi_rready_i : ar_hs;
    rdata_d  = ar_hs ? rd_word : rdata_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q       <= '0;
      rr_q         <= '0;
      last_valid_q <= 1'b0;
      last_ch_q    <= '0;
      bvalid_q     <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
    end else begin
      busy_q       <= busy_d;
      rr_q         <= rr_d;
      last_valid_q <= last_valid_d;
      last_ch_q    <= last_ch_d;
      bvalid_q     <= bvalid_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
    end
  end

endmodule
